sinusoidal_oscillator_multi: RTL and testbench

Parametrised, multi-channel successor to the single pendulum oscillator core. It holds CHANNELS independent discrete harmonic oscillators (position x, velocity v) and advances all of them by one step per `step` pulse, using symplectic Euler and one shared time-multiplexed adder datapath. New capabilities are optional damping, selectable saturating or wrapping arithmetic, per-channel initial conditions, overflow/missed-step status, and a coherent multi-channel output snapshot in DAC-ready format. It sits between the oscillator clock divider and the DAC/LCD drivers.

---
 rtl/sinusoidal_oscillator_multi.sv | 164 ++++++++++++++++
 tb/tb_sinusoidal_oscillator_multi.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sinusoidal_oscillator_multi.sv
// Multi-channel discrete harmonic oscillator bank. Symplectic Euler steps run
// through one shared add/subtract datapath, then all output lanes update together.
module sinusoidal_oscillator_multi #(
   parameter int WIDTH         = 17,
   parameter int OUT_W         = 12,
   parameter int CHANNELS      = 2,
   parameter int K_W           = 4,
   parameter int SATURATE      = 1,
   parameter int OFFSET_BINARY = 1
) (
   input  logic                      qzt_clk,
   input  logic                      reset_n,
   input  logic                      step,
   input  logic                      load,
   input  logic [CHANNELS*WIDTH-1:0] x0_bus,
   input  logic [CHANNELS*WIDTH-1:0] v0_bus,
   input  logic [K_W-1:0]            k,
   input  logic                      damp_en,
   input  logic [3:0]                damp_shift,
   output logic [CHANNELS*OUT_W-1:0] wave_bus,
   output logic                      wave_valid,
   output logic                      busy,
   output logic                      overflow,
   output logic                      step_missed
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW = WIDTH + 2;
   localparam logic signed [SW-1:0] MAX_S = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_S = {3'b111, {(WIDTH-1){1'b0}}};
   localparam logic [OUT_W-1:0] ENC_ZERO = (OFFSET_BINARY != 0) ? {1'b1, {(OUT_W-1){1'b0}}} : '0;

   typedef enum logic [1:0] {IDLE, CALC_V, CALC_X, DONE} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             chan_q, chan_d;
   logic signed [WIDTH-1:0]   x_q [CHANNELS];
   logic signed [WIDTH-1:0]   x_d [CHANNELS];
   logic signed [WIDTH-1:0]   v_q [CHANNELS];
   logic signed [WIDTH-1:0]   v_d [CHANNELS];
   logic [CHANNELS*OUT_W-1:0] wave_q, wave_d;
   logic                      wave_valid_q, wave_valid_d;
   logic                      busy_q, busy_d;
   logic                      overflow_q, overflow_d;
   logic                      step_missed_q, step_missed_d;

   logic signed [WIDTH-1:0] cur_x, cur_v, sh, dsh, fit_val;
   logic signed [SW-1:0]    sum, damp_e;
   logic                    is_v, ovf;

   function automatic logic [OUT_W-1:0] encode(input logic signed [WIDTH-1:0] xv);
      logic [OUT_W-1:0] s;
      s = xv[WIDTH-1 -: OUT_W];
      if (OFFSET_BINARY != 0) s[OUT_W-1] = ~s[OUT_W-1];
      return s;
   endfunction

   function automatic logic signed [SW-1:0] ext(input logic signed [WIDTH-1:0] a);
      return {{2{a[WIDTH-1]}}, a};
   endfunction

   // Shared datapath: CALC_V computes v - (x>>>k) - damping, CALC_X computes x + (v>>>k)
   always_comb begin
      cur_x  = x_q[chan_q];
      cur_v  = v_q[chan_q];
      is_v   = (state_q == CALC_V);
      sh     = (is_v ? cur_x : cur_v) >>> k;
      dsh    = cur_v >>> damp_shift;
      damp_e = (is_v && damp_en) ? ext(dsh) : '0;
      if (is_v) sum = ext(cur_v) - ext(sh) - damp_e;
      else      sum = ext(cur_x) + ext(sh);
      ovf = (sum > MAX_S) || (sum < MIN_S);
      if (ovf && (SATURATE != 0)) fit_val = (sum > MAX_S) ? MAX_S[WIDTH-1:0] : MIN_S[WIDTH-1:0];
      else                        fit_val = sum[WIDTH-1:0];
   end

   always_comb begin
      state_d       = state_q;
      chan_d        = chan_q;
      x_d           = x_q;
      v_d           = v_q;
      wave_d        = wave_q;
      wave_valid_d  = 1'b0;
      busy_d        = busy_q;
      overflow_d    = overflow_q;
      step_missed_d = step_missed_q;
      if (load) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            x_d[c] = x0_bus[c*WIDTH +: WIDTH];
            v_d[c] = v0_bus[c*WIDTH +: WIDTH];
            wave_d[c*OUT_W +: OUT_W] = encode(x_d[c]);
         end
         wave_valid_d  = 1'b1;
         state_d       = IDLE;
         chan_d        = '0;
         busy_d        = 1'b0;
         overflow_d    = 1'b0;
         step_missed_d = 1'b0;
      end else begin
         if (step && (state_q != IDLE)) step_missed_d = 1'b1;
         case (state_q)
            IDLE: begin
               if (step) begin
                  state_d = CALC_V;
                  chan_d  = '0;
                  busy_d  = 1'b1;
               end
            end
            CALC_V: begin
               v_d[chan_q] = fit_val;
               if (ovf) overflow_d = 1'b1;
               state_d = CALC_X;
            end
            CALC_X: begin
               x_d[chan_q] = fit_val;
               if (ovf) overflow_d = 1'b1;
               // Lanes are captured on entry to DONE so wave_valid and wave_bus align
               if (chan_q == CW'(CHANNELS-1)) begin
                  state_d      = DONE;
                  wave_valid_d = 1'b1;
                  for (int unsigned c = 0; c < CHANNELS; c++)
                     wave_d[c*OUT_W +: OUT_W] = encode(x_d[c]);
               end else begin
                  chan_d  = chan_q + 1'b1;
                  state_d = CALC_V;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge qzt_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         chan_q        <= '0;
         x_q           <= '{default: '0};
         v_q           <= '{default: '0};
         wave_q        <= {CHANNELS{ENC_ZERO}};
         wave_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         overflow_q    <= 1'b0;
         step_missed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         chan_q        <= chan_d;
         x_q           <= x_d;
         v_q           <= v_d;
         wave_q        <= wave_d;
         wave_valid_q  <= wave_valid_d;
         busy_q        <= busy_d;
         overflow_q    <= overflow_d;
         step_missed_q <= step_missed_d;
      end
   end

   assign wave_bus    = wave_q;
   assign wave_valid  = wave_valid_q;
   assign busy        = busy_q;
   assign overflow    = overflow_q;
   assign step_missed = step_missed_q;
endmodule

// File: tb/tb_sinusoidal_oscillator_multi.sv
// Bench for sinusoidal_oscillator_multi: a saturating and a wrapping instance
// share stimulus and are compared against an integer oscillator model.
module tb_sinusoidal_oscillator_multi;
   localparam int W  = 17;
   localparam int OW = 12;
   localparam int CH = 2;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic            reset_n, step, load, damp_en;
   logic [3:0]      k, damp_shift;
   logic [CH*W-1:0] x0_bus, v0_bus;
   logic [CH*OW-1:0] wave_s, wave_w;
   logic valid_s, valid_w, busy_s, busy_w, ovf_s, ovf_w, miss_s, miss_w;

   sinusoidal_oscillator_multi #(.WIDTH(W), .OUT_W(OW), .CHANNELS(CH), .K_W(4),
      .SATURATE(1), .OFFSET_BINARY(1)) dut (
      .qzt_clk(clk), .reset_n(reset_n), .step(step), .load(load),
      .x0_bus(x0_bus), .v0_bus(v0_bus), .k(k), .damp_en(damp_en), .damp_shift(damp_shift),
      .wave_bus(wave_s), .wave_valid(valid_s), .busy(busy_s), .overflow(ovf_s),
      .step_missed(miss_s));

   sinusoidal_oscillator_multi #(.WIDTH(W), .OUT_W(OW), .CHANNELS(CH), .K_W(4),
      .SATURATE(0), .OFFSET_BINARY(1)) dut_w (
      .qzt_clk(clk), .reset_n(reset_n), .step(step), .load(load),
      .x0_bus(x0_bus), .v0_bus(v0_bus), .k(k), .damp_en(damp_en), .damp_shift(damp_shift),
      .wave_bus(wave_w), .wave_valid(valid_w), .busy(busy_w), .overflow(ovf_w),
      .step_missed(miss_w));

   int tests = 0;
   int fails = 0;
   int mx [2][CH];
   int mv [2][CH];
   bit movf [2];
   int lx [CH];
   int lv [CH];

   // Model index 0 saturates, index 1 wraps
   function automatic int fit(int r, bit sat);
      if (r > 65535)  return sat ? 65535 : r - 131072;
      if (r < -65536) return sat ? -65536 : r + 131072;
      return r;
   endfunction

   function automatic bit outside(int r);
      return (r > 65535) || (r < -65536);
   endfunction

   function automatic logic [OW-1:0] enc(int xv);
      int u;
      u = (xv + 65536) / 32;
      return OW'(u);
   endfunction

   function automatic logic [CH*OW-1:0] exp_wave(int m);
      logic [CH*OW-1:0] r;
      for (int c = 0; c < CH; c++) r[c*OW +: OW] = enc(mx[m][c]);
      return r;
   endfunction

   function automatic int lane0(logic [CH*OW-1:0] wv);
      return int'(wv[OW-1:0]) - 2048;
   endfunction

   task automatic model_step(input int kk, input bit de, input int ds);
      int nv, nx;
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < CH; c++) begin
            nv = mv[m][c] - (mx[m][c] >>> kk) - (de ? (mv[m][c] >>> ds) : 0);
            if (outside(nv)) movf[m] = 1'b1;
            mv[m][c] = fit(nv, m == 0);
            nx = mx[m][c] + (mv[m][c] >>> kk);
            if (outside(nx)) movf[m] = 1'b1;
            mx[m][c] = fit(nx, m == 0);
         end
   endtask

   task automatic model_zero();
      for (int m = 0; m < 2; m++) begin
         movf[m] = 1'b0;
         for (int c = 0; c < CH; c++) begin
            mx[m][c] = 0;
            mv[m][c] = 0;
         end
      end
   endtask

   task automatic drive_load_bus();
      for (int c = 0; c < CH; c++) begin
         x0_bus[c*W +: W] = W'(lx[c]);
         v0_bus[c*W +: W] = W'(lv[c]);
      end
   endtask

   task automatic model_load();
      for (int m = 0; m < 2; m++) begin
         movf[m] = 1'b0;
         for (int c = 0; c < CH; c++) begin
            mx[m][c] = lx[c];
            mv[m][c] = lv[c];
         end
      end
   endtask

   task automatic do_load();
      drive_load_bus();
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      model_load();
   endtask

   // Pulses step, waits for wave_valid (bounded), then one more cycle back to IDLE
   task automatic run_step(input int kk, input bit de, input int ds, output int lat);
      k = 4'(kk); damp_en = de; damp_shift = 4'(ds);
      step = 1'b1;
      lat = -1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) step = 1'b0;
         if (valid_s) begin
            lat = cyc;
            break;
         end
      end
      model_step(kk, de, ds);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int lat;
      tests++; if (wave_s !== 24'h800800) begin fails++; $display("FAIL reset_wave got=%h exp=%h", wave_s, 24'h800800); end
      tests++; if ({busy_s, valid_s, ovf_s, miss_s} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {busy_s, valid_s, ovf_s, miss_s}); end
      lx = '{24576, 0}; lv = '{0, 0};
      do_load();
      k = 4'd4; step = 1'b1;
      @(posedge clk); #1; step = 1'b0;
      @(posedge clk); #1; step = 1'b1;
      @(posedge clk); #1; step = 1'b0;
      reset_n = 1'b0;
      #1;
      tests++; if ({busy_s, miss_s, wave_s} !== {2'b00, 24'h800800}) begin fails++; $display("FAIL reset_async got busy=%b miss=%b wave=%h exp 0 0 800800", busy_s, miss_s, wave_s); end
      repeat (2) @(posedge clk);
      #1; reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_zero();
      tests++; if (wave_s !== 24'h800800) begin fails++; $display("FAIL reset_mid_wave got=%h exp=%h", wave_s, 24'h800800); end
      tests++; if ({busy_s, valid_s, ovf_s, miss_s} !== 4'b0) begin fails++; $display("FAIL reset_mid_flags got=%b exp=0000", {busy_s, valid_s, ovf_s, miss_s}); end
      run_step(4, 1'b0, 0, lat);
      tests++; if (lat != 5) begin fails++; $display("FAIL reset_first_latency got=%0d exp=5", lat); end
      tests++; if (wave_s !== exp_wave(0)) begin fails++; $display("FAIL reset_first_wave got=%h exp=%h", wave_s, exp_wave(0)); end
   endtask

   task automatic test_single_step();
      int lat;
      lx = '{24576, 0}; lv = '{0, 0};
      do_load();
      tests++; if (valid_s !== 1'b1 || busy_s !== 1'b0) begin fails++; $display("FAIL load_pulse got valid=%b busy=%b exp 1 0", valid_s, busy_s); end
      tests++; if (wave_s !== exp_wave(0)) begin fails++; $display("FAIL load_wave got=%h exp=%h", wave_s, exp_wave(0)); end
      @(posedge clk); #1;
      run_step(4, 1'b0, 0, lat);
      tests++; if (lat != 5) begin fails++; $display("FAIL step_latency got=%0d exp=5", lat); end
      tests++; if (wave_s !== 24'h800AFD) begin fails++; $display("FAIL step_wave_const got=%h exp=800afd", wave_s); end
      tests++; if (wave_s !== exp_wave(0)) begin fails++; $display("FAIL step_wave_model got=%h exp=%h", wave_s, exp_wave(0)); end
      tests++; if (valid_s !== 1'b0 || busy_s !== 1'b0) begin fails++; $display("FAIL step_pulse_end got valid=%b busy=%b exp 0 0", valid_s, busy_s); end
   endtask

   task automatic test_period();
      int lat, s, prev, last_cross, ncross, pk;
      bit bad_gap;
      lx = '{24576, 0}; lv = '{0, 0};
      do_load();
      prev = 0; last_cross = -1; ncross = 0; pk = 0; bad_gap = 0;
      for (int n = 1; n <= 300; n++) begin
         run_step(4, 1'b0, 0, lat);
         tests++; if (lat != 5 || wave_s !== exp_wave(0)) begin fails++; $display("FAIL period_step%0d got lat=%0d wave=%h exp lat=5 wave=%h", n, lat, wave_s, exp_wave(0)); end
         s = lane0(wave_s);
         if (prev < 0 && s >= 0) begin
            if (last_cross >= 0 && (n - last_cross) != 100 && (n - last_cross) != 101) begin
               bad_gap = 1'b1;
               $display("FAIL period_gap got=%0d exp=100or101", n - last_cross);
            end
            last_cross = n;
            ncross++;
         end
         if ((s < 0 ? -s : s) > pk) pk = (s < 0 ? -s : s);
         prev = s;
      end
      tests++; if (bad_gap || ncross < 2) begin fails++; $display("FAIL period_crossings got crossings=%0d badgap=%0d exp >=2 and 0", ncross, bad_gap); end
      tests++; if (pk * 32 < 24084 || pk * 32 > 25067) begin fails++; $display("FAIL period_peak got=%0d exp 24084..25067", pk * 32); end
      tests++; if (ovf_s !== 1'b0) begin fails++; $display("FAIL period_overflow got=%b exp=0", ovf_s); end
   endtask

   task automatic test_saturation();
      int lat;
      lx = '{-65536, 0}; lv = '{65535, 0};
      do_load();
      tests++; if (ovf_s !== 1'b0 || ovf_w !== 1'b0) begin fails++; $display("FAIL sat_pre got=%b%b exp=00", ovf_s, ovf_w); end
      run_step(0, 1'b0, 0, lat);
      tests++; if (ovf_s !== 1'b1 || ovf_w !== 1'b1) begin fails++; $display("FAIL sat_overflow got=%b%b exp=11", ovf_s, ovf_w); end
      tests++; if (wave_s[OW-1:0] !== 12'h7FF || wave_s !== exp_wave(0)) begin fails++; $display("FAIL sat_clamp_wave got=%h exp=%h", wave_s, exp_wave(0)); end
      tests++; if (wave_w[OW-1:0] !== 12'hFFF || wave_w !== exp_wave(1)) begin fails++; $display("FAIL sat_wrap_wave got=%h exp=%h", wave_w, exp_wave(1)); end
      do_load();
      tests++; if (ovf_s !== 1'b0 || ovf_w !== 1'b0) begin fails++; $display("FAIL sat_load_clear got=%b%b exp=00", ovf_s, ovf_w); end
      @(posedge clk); #1;
   endtask

   task automatic test_damping();
      int lat, s, a, run_sign, run_peak, np;
      int peaks [$];
      bit bad;
      lx = '{24576, 0}; lv = '{0, 0};
      do_load();
      run_sign = 1; run_peak = 0; bad = 0;
      for (int n = 1; n <= 200; n++) begin
         run_step(4, 1'b1, 3, lat);
         tests++; if (lat != 5 || wave_s !== exp_wave(0)) begin fails++; $display("FAIL damp_step%0d got lat=%0d wave=%h exp lat=5 wave=%h", n, lat, wave_s, exp_wave(0)); end
         s = lane0(wave_s);
         a = (s < 0) ? -s : s;
         if ((s < 0 ? -1 : 1) != run_sign) begin
            peaks.push_back(run_peak);
            run_sign = -run_sign;
            run_peak = 0;
         end
         if (a > run_peak) run_peak = a;
      end
      peaks.push_back(run_peak);
      np = peaks.size();
      for (int i = 0; i + 1 < np; i++)
         if (peaks[i] >= 8 && peaks[i+1] >= peaks[i]) bad = 1'b1;
      tests++; if (bad) begin fails++; $display("FAIL damp_peaks got non-decreasing half-period peaks exp strictly decreasing"); end
      tests++; if (a >= 96) begin fails++; $display("FAIL damp_final got=%0d exp <3072", a * 32); end
      damp_en = 1'b0;
   endtask

   task automatic test_random();
      int lat, kk, ds;
      bit de;
      for (int it = 0; it < 6; it++) begin
         for (int c = 0; c < CH; c++) begin
            lx[c] = int'($urandom_range(0, 131071)) - 65536;
            lv[c] = int'($urandom_range(0, 131071)) - 65536;
         end
         do_load();
         for (int n = 0; n < 10; n++) begin
            kk = int'($urandom_range(0, 7));
            de = 1'($urandom_range(0, 1));
            ds = int'($urandom_range(0, 15));
            run_step(kk, de, ds, lat);
            tests++; if (lat != 5 || wave_s !== exp_wave(0) || ovf_s !== movf[0]) begin fails++; $display("FAIL rand_sat it%0d n%0d got lat=%0d wave=%h ovf=%b exp lat=5 wave=%h ovf=%b", it, n, lat, wave_s, ovf_s, exp_wave(0), movf[0]); end
            tests++; if (wave_w !== exp_wave(1) || ovf_w !== movf[1]) begin fails++; $display("FAIL rand_wrap it%0d n%0d got wave=%h ovf=%b exp wave=%h ovf=%b", it, n, wave_w, ovf_w, exp_wave(1), movf[1]); end
         end
      end
      damp_en = 1'b0;
   endtask

   task automatic test_collisions();
      int lat, vcount;
      bit extra;
      lx = '{12288, -5000}; lv = '{300, 700};
      do_load();
      @(posedge clk); #1;
      k = 4'd4; step = 1'b1;
      lat = -1; vcount = 0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) begin
            tests++; if (busy_s !== 1'b1) begin fails++; $display("FAIL coll_busy got=%b exp=1", busy_s); end
            step = 1'b1;
         end else step = 1'b0;
         if (cyc == 2) begin
            tests++; if (miss_s !== 1'b1) begin fails++; $display("FAIL coll_missed got=%b exp=1", miss_s); end
         end
         if (valid_s) begin
            vcount++;
            if (lat < 0) lat = cyc;
         end
      end
      model_step(4, 1'b0, 0);
      tests++; if (lat != 5 || vcount != 1 || wave_s !== exp_wave(0)) begin fails++; $display("FAIL coll_drop got lat=%0d pulses=%0d wave=%h exp lat=5 pulses=1 wave=%h", lat, vcount, wave_s, exp_wave(0)); end

      step = 1'b1;
      @(posedge clk); #1; step = 1'b0;
      @(posedge clk); #1;
      lx = '{-20000, 8000}; lv = '{-900, 50};
      do_load();
      tests++; if (valid_s !== 1'b1 || busy_s !== 1'b0 || miss_s !== 1'b0) begin fails++; $display("FAIL coll_load_abort got valid=%b busy=%b miss=%b exp 1 0 0", valid_s, busy_s, miss_s); end
      tests++; if (wave_s !== exp_wave(0)) begin fails++; $display("FAIL coll_load_wave got=%h exp=%h", wave_s, exp_wave(0)); end
      @(posedge clk); #1;
      run_step(3, 1'b0, 0, lat);
      tests++; if (lat != 5 || wave_s !== exp_wave(0)) begin fails++; $display("FAIL coll_after_abort got lat=%0d wave=%h exp lat=5 wave=%h", lat, wave_s, exp_wave(0)); end

      lx = '{4096, -4096}; lv = '{0, 0};
      drive_load_bus();
      load = 1'b1; step = 1'b1;
      @(posedge clk); #1;
      load = 1'b0; step = 1'b0;
      model_load();
      tests++; if (valid_s !== 1'b1 || busy_s !== 1'b0 || miss_s !== 1'b0 || wave_s !== exp_wave(0)) begin fails++; $display("FAIL coll_load_step got valid=%b busy=%b miss=%b wave=%h exp 1 0 0 %h", valid_s, busy_s, miss_s, wave_s, exp_wave(0)); end
      extra = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(posedge clk); #1;
         if (valid_s || busy_s) extra = 1'b1;
      end
      tests++; if (extra) begin fails++; $display("FAIL coll_step_ignored got activity=1 exp=0"); end
   endtask

   initial begin
      reset_n = 1'b0; step = 1'b0; load = 1'b0; k = '0;
      damp_en = 1'b0; damp_shift = '0; x0_bus = '0; v0_bus = '0;
      model_zero();
      repeat (3) @(posedge clk);
      #1; reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single_step();
      test_period();
      test_saturation();
      test_damping();
      test_random();
      test_collisions();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
